// File: rtl/aliens_bank_rom_ctrl_if.sv
// -----------------------------------------------------------------------------
// aliens_bank_rom_ctrl_if
// Bundles the CPU-side bus signals and the external ROM/SDRAM request port of
// the Aliens banked-ROM controller.
//   slave  : view taken by aliens_bank_rom_ctrl (CPU bus in, ROM request out)
//   master : view taken by the surrounding system / bench
// Signals:
//   cpu_as_n, cpu_rnw, cpu_addr[15:0], cpu_dout[7:0]  CPU strobe/direction/addr/data
//   rom_din[7:0], rom_cs, cpu_wait                    data back to CPU mux, select, stall
//   bank[4:0], rmrd, init, woco, bk4                  bank/control register fields
//   rom_req, rom_addr[18:0], rom_ack, rom_data[7:0]   ROM port request/response
//   rom_err                                           sticky timeout flag
// -----------------------------------------------------------------------------
interface aliens_bank_rom_ctrl_if;
   logic        cpu_as_n;
   logic        cpu_rnw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic [7:0]  rom_din;
   logic        rom_cs;
   logic        cpu_wait;
   logic [4:0]  bank;
   logic        rmrd;
   logic        init;
   logic        woco;
   logic        bk4;
   logic        rom_req;
   logic [18:0] rom_addr;
   logic        rom_ack;
   logic [7:0]  rom_data;
   logic        rom_err;

   modport slave (
      input  cpu_as_n, cpu_rnw, cpu_addr, cpu_dout, rom_ack, rom_data,
      output rom_din, rom_cs, cpu_wait, bank, rmrd, init, woco, bk4,
             rom_req, rom_addr, rom_err
   );

   modport master (
      output cpu_as_n, cpu_rnw, cpu_addr, cpu_dout, rom_ack, rom_data,
      input  rom_din, rom_cs, cpu_wait, bank, rmrd, init, woco, bk4,
             rom_req, rom_addr, rom_err
   );
endinterface

// File: rtl/aliens_bank_rom_ctrl.sv
// -----------------------------------------------------------------------------
// aliens_bank_rom_ctrl
// Sequences CPU reads of the fixed (0x8000-0xFFFF) and banked (0x2000-0x3FFF)
// ROM windows onto a request/acknowledge ROM port, stalling the CPU with
// cpu_wait until data returns or a timeout aborts the access. Also holds the
// write-only bank/control register {woco, init, rmrd, bank[4:0]}.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      aliens_bank_rom_ctrl_if.slave (CPU bus + ROM port, see interface)
// -----------------------------------------------------------------------------
module aliens_bank_rom_ctrl #(
   parameter logic [15:0] BANKREG_ADDR = 16'h1F90,
   parameter int          TIMEOUT      = 64,
   parameter int          TO_W         = 7
) (
   input  logic                   clk,
   input  logic                   reset_n,
   aliens_bank_rom_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic            r_as_n_d;
   logic            r_cs_d;
   logic [7:0]      r_bankreg;
   logic            r_rom_req;
   logic            w_rom_req_next;
   logic [18:0]     r_rom_addr;
   logic [18:0]     w_rom_addr_next;
   logic [7:0]      r_rom_din;
   logic [7:0]      w_rom_din_next;
   logic            r_rom_err;
   logic            w_rom_err_next;
   logic [TO_W-1:0] r_to_cnt;
   logic [TO_W-1:0] w_to_cnt_next;

   logic            w_fixed;
   logic            w_banked;
   logic            w_rom_cs;
   logic            w_first;
   logic            w_bank_wr;
   logic            w_start;
   logic [18:0]     w_rom_addr_dec;

   // Window decode and the ROM byte address each window maps to.
   assign w_fixed        = bus.cpu_addr[15];
   assign w_banked       = (bus.cpu_addr[15:13] == 3'b001);
   assign w_rom_cs       = !bus.cpu_as_n & bus.cpu_rnw & (w_fixed | w_banked);
   assign w_rom_addr_dec = w_fixed ? {4'b1000, bus.cpu_addr[14:0]}
                                   : {1'b0, r_bankreg[4:0], bus.cpu_addr[12:0]};

   // First cycle of a strobe: cpu_as_n was high on the previous edge.
   assign w_first   = !bus.cpu_as_n & r_as_n_d;
   assign w_bank_wr = w_first & !bus.cpu_rnw & (bus.cpu_addr == BANKREG_ADDR);

   // A new request starts when rom_cs rises, or when a fresh strobe begins
   // while rom_cs was already high (address held across back-to-back strobes).
   assign w_start = w_rom_cs & (!r_cs_d | w_first);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_as_n_d <= 1'b1;
         r_cs_d   <= 1'b0;
      end else begin
         r_as_n_d <= bus.cpu_as_n;
         r_cs_d   <= w_rom_cs;
      end
   end

   // Bank/control register; only the first edge of a write strobe latches, so
   // data changing later in the same strobe is ignored. Independent of the
   // FSM: an in-flight request keeps the rom_addr it was issued with.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bankreg <= 8'h00;
      end else if (w_bank_wr) begin
         r_bankreg <= bus.cpu_dout;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_rom_req  <= 1'b0;
         r_rom_addr <= 19'h0;
         r_rom_din  <= 8'hFF;
         r_rom_err  <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_rom_req  <= w_rom_req_next;
         r_rom_addr <= w_rom_addr_next;
         r_rom_din  <= w_rom_din_next;
         r_rom_err  <= w_rom_err_next;
         r_to_cnt   <= w_to_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_rom_req_next  = r_rom_req;
      w_rom_addr_next = r_rom_addr;
      w_rom_din_next  = r_rom_din;
      w_rom_err_next  = r_rom_err;
      w_to_cnt_next   = r_to_cnt;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_rom_addr_next = w_rom_addr_dec;
               w_rom_req_next  = 1'b1;
               w_to_cnt_next   = '0;
               w_state_next    = REQ;
            end
         end
         REQ: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (bus.rom_ack) begin
               w_rom_din_next = bus.rom_data;
               w_rom_req_next = 1'b0;
               w_state_next   = DONE;
            end else if (r_to_cnt == TO_LAST) begin
               w_rom_din_next = 8'hFF;
               w_rom_err_next = 1'b1;
               w_rom_req_next = 1'b0;
               w_state_next   = DONE;
            end else begin
               w_to_cnt_next = r_to_cnt + 1'b1;
            end
         end
         DONE: begin
            // Hold until the strobe ends so one strobe yields one request.
            if (bus.cpu_as_n) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_rom_req_next = 1'b0;
         end
      endcase
   end

   assign bus.rom_cs   = w_rom_cs;
   assign bus.cpu_wait = w_rom_cs & (r_state != DONE);
   assign bus.rom_din  = r_rom_din;
   assign bus.rom_req  = r_rom_req;
   assign bus.rom_addr = r_rom_addr;
   assign bus.rom_err  = r_rom_err;
   assign bus.bank     = r_bankreg[4:0];
   assign bus.rmrd     = r_bankreg[5];
   assign bus.init     = r_bankreg[6];
   assign bus.woco     = r_bankreg[7];
   assign bus.bk4      = r_bankreg[4];

endmodule

// File: tb/tb_aliens_bank_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aliens_bank_rom_ctrl
// Drives CPU bus cycles and a ROM responder with programmable ack latency.
// The expected values come from a transaction-level model: window ranges and
// ROM address arithmetic, the last bank register value, the sticky error and
// the expected stall length per access.
// -----------------------------------------------------------------------------
module tb_aliens_bank_rom_ctrl;
   localparam int TIMEOUT = 64;

   logic clk;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   aliens_bank_rom_ctrl_if bus();

   aliens_bank_rom_ctrl #(
      .BANKREG_ADDR (16'h1F90),
      .TIMEOUT      (TIMEOUT),
      .TO_W         (7)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   logic [7:0]  m_bank     = 8'h00;
   logic        m_err      = 1'b0;
   logic [18:0] m_exp_addr = 19'h0;
   logic [7:0]  m_exp_din  = 8'hFF;
   bit          cmp_en     = 1'b0;

   // ---------------- responder controls ----------------
   int          rsp_lat    = 1;
   bit          rsp_noack  = 1'b0;
   logic [7:0]  rsp_data   = 8'h00;
   int          stray_req  = 0;
   int          req_rises  = 0;
   int          last_req_cycles = 0;
   logic [18:0] seen_addr  = 19'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [15:0] a);
      return (a >= 16'h8000) || ((a >= 16'h2000) && (a < 16'h4000));
   endfunction

   function automatic logic [18:0] exp_addr(input logic [15:0] a);
      int v;
      if (a >= 16'h8000) v = 32'h40000 + (int'(a) - 32'h8000);
      else               v = int'(m_bank[4:0]) * 8192 + (int'(a) - 32'h2000);
      return v[18:0];
   endfunction

   // ---------------- ROM responder ----------------
   initial begin : responder
      int  cnt;
      bit  prev;
      bit  served;
      int  stray_done;
      cnt = 0; prev = 1'b0; served = 1'b0; stray_done = 0;
      bus.rom_ack  = 1'b0;
      bus.rom_data = 8'h00;
      forever begin
         @(negedge clk);
         bus.rom_ack  = 1'b0;
         bus.rom_data = 8'($urandom);
         if (bus.rom_req && !prev) begin
            req_rises++;
            seen_addr = bus.rom_addr;
         end
         if (!bus.rom_req && prev) last_req_cycles = cnt;
         prev = bus.rom_req;
         if (bus.rom_req) begin
            cnt++;
            if (!rsp_noack && !served && cnt == rsp_lat) begin
               bus.rom_ack  = 1'b1;
               bus.rom_data = rsp_data;
               served       = 1'b1;
            end
         end else begin
            cnt    = 0;
            served = 1'b0;
         end
         if (stray_req != stray_done) begin
            bus.rom_ack  = 1'b1;
            bus.rom_data = 8'h77;
            stray_done   = stray_req;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   initial begin : compare
      bit exp_cs;
      forever begin
         @(negedge clk);
         #2;
         if (cmp_en) begin
            exp_cs = !bus.cpu_as_n && bus.cpu_rnw && in_window(bus.cpu_addr);
            chk("rom_cs",  bus.rom_cs,  exp_cs);
            chk("bank",    bus.bank,    m_bank[4:0]);
            chk("rmrd",    bus.rmrd,    m_bank[5]);
            chk("init",    bus.init,    m_bank[6]);
            chk("woco",    bus.woco,    m_bank[7]);
            chk("bk4",     bus.bk4,     m_bank[4]);
            chk("rom_err", bus.rom_err, m_err);
            if (!exp_cs) chk("wait_no_cs", bus.cpu_wait, 1'b0);
            if (bus.rom_req) chk("rom_addr", bus.rom_addr, m_exp_addr);
            if (exp_cs && !bus.cpu_wait) chk("rom_din", bus.rom_din, m_exp_din);
         end
      end
   end

   // One full CPU bus cycle; returns the number of stalled cycles observed.
   task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                            input int lat, input bit noack, input int hold,
                            output int nwait);
      bit is_rom;
      int rises0;
      int exp_wait;
      is_rom = rnw && in_window(a);
      rises0 = req_rises;
      if (is_rom) begin
         m_exp_addr = exp_addr(a);
         m_exp_din  = noack ? 8'hFF : d;
         rsp_lat    = lat;
         rsp_noack  = noack;
         rsp_data   = d;
      end
      @(negedge clk);
      bus.cpu_addr = a;
      bus.cpu_rnw  = rnw;
      bus.cpu_dout = rnw ? 8'($urandom) : d;
      bus.cpu_as_n = 1'b0;
      nwait = 0;
      forever begin
         #1;
         if (!bus.cpu_wait) break;
         nwait++;
         if (nwait > 200) begin
            chk("wait_bound", 32'(nwait), 32'd0);
            break;
         end
         @(negedge clk);
      end
      if (is_rom && noack) m_err = 1'b1;
      exp_wait = !is_rom ? 0 : (noack ? TIMEOUT + 1 : lat + 1);
      chk("wait_cycles", 32'(nwait), 32'(exp_wait));
      @(negedge clk);
      if (!rnw && a == 16'h1F90) m_bank = d;
      bus.cpu_dout = ~d;   // later data in the same strobe must not latch
      repeat (hold) @(negedge clk);
      bus.cpu_as_n = 1'b1;
      @(negedge clk);
      chk("req_rises", 32'(req_rises - rises0), is_rom ? 32'd1 : 32'd0);
      $display("txn addr=%04h rnw=%0d data=%02h lat=%0d noack=%0d wait=%0d rom_din=%02h err=%0d",
               a, rnw, d, lat, noack, nwait, bus.rom_din, bus.rom_err);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int          n;
      int          rises0;
      int          k;
      logic [15:0] a;
      bus.cpu_as_n = 1'b1;
      bus.cpu_rnw  = 1'b1;
      bus.cpu_addr = 16'h0000;
      bus.cpu_dout = 8'h00;
      reset_n      = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bank",     bus.bank,     5'h00);
      chk("rst_woco",     bus.woco,     1'b0);
      chk("rst_rom_req",  bus.rom_req,  1'b0);
      chk("rst_rom_addr", bus.rom_addr, 19'h0);
      chk("rst_rom_din",  bus.rom_din,  8'hFF);
      chk("rst_rom_err",  bus.rom_err,  1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // Bank register write
      cpu_cycle(16'h1F90, 1'b0, 8'hD3, 1, 1'b0, 2, n);
      #1;
      chk("lit_bank", bus.bank, 5'h13);
      chk("lit_bk4",  bus.bk4,  1'b1);
      chk("lit_rmrd", bus.rmrd, 1'b0);
      chk("lit_init", bus.init, 1'b1);
      chk("lit_woco", bus.woco, 1'b1);

      // Banked read, ack after 5 cycles
      cpu_cycle(16'h2ABC, 1'b1, 8'h5A, 5, 1'b0, 0, n);
      chk("lit_banked_addr", seen_addr, 19'h26ABC);
      chk("lit_banked_wait", 32'(n), 32'd6);
      chk("lit_banked_din",  bus.rom_din, 8'h5A);

      // Fixed read with a long strobe
      cpu_cycle(16'hC123, 1'b1, 8'h3C, 3, 1'b0, 12, n);
      chk("lit_fixed_addr", seen_addr, 19'h44123);

      // Timeout, then a good read with the error still sticky
      cpu_cycle(16'hA000, 1'b1, 8'h00, 1, 1'b1, 1, n);
      chk("lit_to_wait",     32'(n), 32'd65);
      chk("lit_to_req_cyc",  32'(last_req_cycles), 32'd64);
      chk("lit_to_din",      bus.rom_din, 8'hFF);
      chk("lit_to_err",      bus.rom_err, 1'b1);
      cpu_cycle(16'h2000, 1'b1, 8'h11, 2, 1'b0, 0, n);
      chk("lit_after_to_err", bus.rom_err, 1'b1);

      // Ignored write to a ROM window, non-ROM read
      cpu_cycle(16'h8000, 1'b0, 8'h55, 1, 1'b0, 1, n);
      cpu_cycle(16'h0400, 1'b1, 8'h00, 1, 1'b0, 1, n);
      chk("lit_nonrom_wait", 32'(n), 32'd0);

      // Strobe abandoned while the request is outstanding
      rises0     = req_rises;
      m_exp_addr = exp_addr(16'h3FFF);
      m_exp_din  = 8'hC7;
      rsp_lat    = 6;
      rsp_noack  = 1'b0;
      rsp_data   = 8'hC7;
      @(negedge clk);
      bus.cpu_addr = 16'h3FFF;
      bus.cpu_rnw  = 1'b1;
      bus.cpu_as_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.cpu_as_n = 1'b1;
      k = 0;
      while (bus.rom_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("abandon_req_done", bus.rom_req, 1'b0);
      chk("abandon_rises",    32'(req_rises - rises0), 32'd1);
      cpu_cycle(16'hFFFF, 1'b1, 8'hE1, 4, 1'b0, 0, n);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         k = $urandom_range(0, 9);
         if (k <= 1) begin
            cpu_cycle(16'h1F90, 1'b0, 8'($urandom), 1, 1'b0, $urandom_range(0, 2), n);
         end else if (k == 2) begin
            cpu_cycle(16'($urandom), 1'b0, 8'($urandom), 1, 1'b0, $urandom_range(0, 2), n);
         end else if (k == 3) begin
            a = ($urandom_range(0, 1) == 0) ? (16'h0000 | 16'($urandom_range(0, 16'h1FFF)))
                                            : (16'h4000 | 16'($urandom_range(0, 16'h3FFF)));
            cpu_cycle(a, 1'b1, 8'h00, 1, 1'b0, $urandom_range(0, 2), n);
         end else begin
            a = ($urandom_range(0, 1) == 0) ? (16'h8000 | 16'($urandom_range(0, 16'h7FFF)))
                                            : (16'h2000 | 16'($urandom_range(0, 16'h1FFF)));
            cpu_cycle(a, 1'b1, 8'($urandom), $urandom_range(1, 8), 1'b0, $urandom_range(0, 3), n);
         end
      end

      // Asynchronous reset while a request is outstanding
      m_exp_addr = exp_addr(16'h9000);
      m_exp_din  = 8'h42;
      rsp_lat    = 30;
      rsp_noack  = 1'b0;
      rsp_data   = 8'h42;
      @(negedge clk);
      bus.cpu_addr = 16'h9000;
      bus.cpu_rnw  = 1'b1;
      bus.cpu_as_n = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("pre_rst_req", bus.rom_req, 1'b1);
      @(posedge clk);
      #2;
      reset_n      = 1'b0;
      bus.cpu_as_n = 1'b1;
      #1;
      chk("async_rst_req",  bus.rom_req, 1'b0);
      chk("async_rst_bank", bus.bank,    5'h00);
      chk("async_rst_din",  bus.rom_din, 8'hFF);
      m_bank = 8'h00;
      m_err  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rises0  = req_rises;
      stray_req++;
      repeat (3) @(negedge clk);
      #1;
      chk("stray_ack_req",   bus.rom_req, 1'b0);
      chk("stray_ack_din",   bus.rom_din, 8'hFF);
      chk("stray_ack_err",   bus.rom_err, 1'b0);
      chk("stray_ack_rises", 32'(req_rises - rises0), 32'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aliens_bank_rom_ctrl.md
Name: aliens_bank_rom_ctrl

Overview:
- Sequences CPU accesses to the program/banked ROM windows on the Aliens CPU bus.
- Holds the CPU bank/control register: ROM bank, RMRD, INIT and WOCO.
- Issues one read request per ROM bus cycle to the external ROM/SDRAM port and stalls the CPU with cpu_wait until data returns or a timeout fires.
- Sits between the CPU core and the combinational address decoder; supplies the BK4/INIT/WOCO inputs to that decoder.

Parameters:
- BANKREG_ADDR, 16'h1F90, CPU address of the bank/control register (write-only).
- TIMEOUT, 64, max clk cycles from rom_req rise to rom_ack before the cycle is aborted.
- TO_W, 7, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_as_n  in  1  CPU address strobe, active low
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  16  CPU address
- cpu_dout  in  8  CPU write data
- rom_din  out  8  ROM read data to CPU mux; valid while rom_cs and not cpu_wait
- rom_cs  out  1  combinational: current cycle targets a ROM window
- cpu_wait  out  1  combinational CPU stall
- bank  out  5  ROM bank register[4:0]
- rmrd  out  1  register bit 5
- init  out  1  register bit 6
- woco  out  1  register bit 7
- bk4  out  1  equals bank[4]
- rom_req  out  1  registered request to ROM port
- rom_addr  out  19  registered ROM byte address
- rom_ack  in  1  one-cycle pulse, data valid
- rom_data  in  8  ROM data, sampled when rom_ack = 1
- rom_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n = 0): bank = 0, rmrd = 0, init = 0, woco = 0, rom_req = 0, rom_addr = 0, rom_din = 8'hFF, rom_err = 0, state = IDLE.
- ROM windows (decided):
  - fixed: cpu_addr[15] = 1 -> rom_addr = {4'b1000, cpu_addr[14:0]}.
  - banked: cpu_addr[15:13] = 3'b001 -> rom_addr = {1'b0, bank, cpu_addr[12:0]}.
- rom_cs = !cpu_as_n & cpu_rnw & (fixed | banked). A write to a ROM window is ignored: no request, no wait.
- Bank register write:
  - Condition: !cpu_as_n, !cpu_rnw, cpu_addr == BANKREG_ADDR.
  - Latches cpu_dout on the first clk edge of the strobe only, tracked by an edge-detect on cpu_as_n.
  - Updated fields are visible the next cycle.
  - A write while state != IDLE still latches; rom_addr of the in-flight request does not change.
- State machine IDLE / REQ / DONE:
  - IDLE: when rom_cs rises, or rom_cs is high on the first cycle of a new strobe:
    - register rom_addr, set rom_req = 1, clear the timeout counter, go to REQ.
    - cpu_wait = 1 combinationally in this same cycle.
  - REQ: rom_req held at 1 and rom_addr stable; the counter increments each cycle.
    - rom_ack = 1: rom_din <= rom_data, rom_req <= 0, go to DONE.
    - counter reaches TIMEOUT - 1 without ack: rom_din <= 8'hFF, rom_err <= 1, rom_req <= 0, go to DONE.
    - rom_ack in the timeout cycle: ack wins and rom_err is unchanged.
  - DONE: cpu_wait = 0. Stay until cpu_as_n = 1, then go to IDLE.
    - A late rom_ack in DONE or IDLE is ignored.
- cpu_wait = rom_cs & (state != DONE).
  - Latency: rom_ack in cycle N -> cpu_wait low in cycle N+1 with rom_din valid.
- Exactly one request per strobe.
  - Back-to-back strobes require cpu_as_n high for at least one clk between them.
  - A strobe abandoned in REQ (cpu_as_n rises) finishes the request, then returns DONE -> IDLE without stalling the next cycle.
- Reset mid-request: rom_req drops asynchronously; the ROM port must tolerate an aborted request.
- rom_err clears only on reset.

Test Plan:
- Reset, then write 8'hD3 to 16'h1F90 -> bank = 5'h13, bk4 = 1, rmrd = 0, init = 1, woco = 1 next cycle.
- Banked read at 16'h2ABC with bank = 5'h13 -> rom_addr = 19'h26ABC, rom_req held until ack after 5 cycles with 8'h5A -> cpu_wait low 1 cycle later, rom_din = 8'h5A.
- Fixed read at 16'hC123 -> rom_addr = 19'h44123; a long strobe produces exactly one rom_req rise.
- Withhold ack -> rom_req drops after 64 cycles, rom_din = 8'hFF, rom_err = 1; the next good read still completes and rom_err stays 1.
- Write to 16'h8000, then read from 16'h0400 -> rom_cs = 0, no rom_req, cpu_wait = 0.
- Assert reset_n low while in REQ -> rom_req = 0 and bank = 0 immediately, without waiting for a clk edge; a later ack is ignored.
